// File: rtl/motor_position_tracker_pkg.sv
// Shared definitions for the solar-tracker position integrator: speed codes,
// ticks-per-step table and per-axis state encodings.
package tracker_pkg;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_MED  = 2'b10;
  localparam logic [1:0] SPD_FAST = 2'b11;

  typedef enum logic [1:0] {
    AX_IDLE  = 2'b00,
    AX_MOVE  = 2'b01,
    AX_LIMIT = 2'b10,
    AX_FAULT = 2'b11
  } axis_state_e;

  // Ticks per 1-degree step minus one, i.e. the phase value on which a step fires.
  function automatic logic [1:0] step_last_phase(input logic [1:0] spd);
    logic [1:0] last;
    case (spd)
      SPD_SLOW: last = 2'd3;
      SPD_MED:  last = 2'd1;
      SPD_FAST: last = 2'd0;
      default:  last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/motor_position_tracker_axis.sv
// One tracker axis: integrates registered pos/neg speed codes into a clamped angle
// with an IDLE/MOVE/LIMIT/FAULT state machine.
module axis_integrator
  import tracker_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int MIN     = 0,
  parameter int MAX     = 90,
  parameter int INIT    = 45
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               home,
  input  logic               tick,
  input  logic [1:0]         code_pos,
  input  logic [1:0]         code_neg,
  output logic [ANGLE_W-1:0] angle,
  output logic               moving,
  output logic               at_limit,
  output logic               in_fault
);

  localparam logic [ANGLE_W-1:0] MIN_A  = ANGLE_W'(MIN);
  localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(MAX);
  localparam logic [ANGLE_W-1:0] INIT_A = ANGLE_W'(INIT);
  localparam logic [ANGLE_W-1:0] ONE_A  = ANGLE_W'(1);
  localparam logic               AT_LIMIT_INIT = (INIT_A == MIN_A) || (INIT_A == MAX_A);

  axis_state_e        state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d, angle_step_s;
  logic [1:0]         phase_q, phase_d;
  logic [1:0]         pos_prev_q, pos_prev_d, neg_prev_q, neg_prev_d;
  logic               moving_q, moving_d, at_limit_q, at_limit_d;
  logic               pos_act_s, neg_act_s, conflict_s, stop_s, code_chg_s;
  logic               blocked_s, step_due_s, step_en_s, lands_s;
  logic [1:0]         spd_s;

  always_comb begin
    pos_act_s    = (code_pos != SPD_STOP);
    neg_act_s    = (code_neg != SPD_STOP);
    conflict_s   = pos_act_s && neg_act_s;
    stop_s       = !pos_act_s && !neg_act_s;
    spd_s        = pos_act_s ? code_pos : code_neg;
    code_chg_s   = (code_pos != pos_prev_q) || (code_neg != neg_prev_q);
    blocked_s    = pos_act_s ? (angle_q == MAX_A) : (angle_q == MIN_A);
    // A tick that coincides with a code change only restarts the phase.
    step_due_s   = tick && !code_chg_s && (phase_q == step_last_phase(spd_s));
    step_en_s    = (state_q == AX_MOVE) && !home && !conflict_s && !stop_s &&
                   !blocked_s && step_due_s;
    angle_step_s = pos_act_s ? (angle_q + ONE_A) : (angle_q - ONE_A);
    lands_s      = (angle_step_s == MIN_A) || (angle_step_s == MAX_A);
  end

  always_comb begin
    state_d = state_q;
    if (home) begin
      state_d = AX_IDLE;
    end else if (conflict_s) begin
      state_d = AX_FAULT;
    end else begin
      case (state_q)
        AX_IDLE, AX_LIMIT: begin
          if (stop_s)         state_d = AX_IDLE;
          else if (blocked_s) state_d = AX_LIMIT;
          else                state_d = AX_MOVE;
        end
        AX_MOVE: begin
          if (stop_s)                    state_d = AX_IDLE;
          else if (blocked_s)            state_d = AX_LIMIT;
          else if (step_en_s && lands_s) state_d = AX_LIMIT;
          else                           state_d = AX_MOVE;
        end
        AX_FAULT: begin
          if (stop_s) state_d = AX_IDLE;
          else        state_d = AX_FAULT;
        end
        default: state_d = AX_IDLE;
      endcase
    end
  end

  always_comb begin
    pos_prev_d = code_pos;
    neg_prev_d = code_neg;
    if (home)           angle_d = INIT_A;
    else if (step_en_s) angle_d = angle_step_s;
    else                angle_d = angle_q;
    if (home || code_chg_s || (state_d != state_q)) begin
      phase_d = 2'd0;
    end else if ((state_q == AX_MOVE) && tick) begin
      phase_d = step_due_s ? 2'd0 : (phase_q + 2'd1);
    end else begin
      phase_d = phase_q;
    end
    moving_d   = (state_d == AX_MOVE);
    at_limit_d = (angle_d == MIN_A) || (angle_d == MAX_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AX_IDLE;
      angle_q    <= INIT_A;
      phase_q    <= 2'd0;
      pos_prev_q <= SPD_STOP;
      neg_prev_q <= SPD_STOP;
      moving_q   <= 1'b0;
      at_limit_q <= AT_LIMIT_INIT;
    end else begin
      state_q    <= state_d;
      angle_q    <= angle_d;
      phase_q    <= phase_d;
      pos_prev_q <= pos_prev_d;
      neg_prev_q <= neg_prev_d;
      moving_q   <= moving_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign angle    = angle_q;
  assign moving   = moving_q;
  assign at_limit = at_limit_q;
  assign in_fault = (state_q == AX_FAULT);

endmodule

// File: rtl/motor_position_tracker.sv
// Closes the simulated tracker loop: registers the drive speed codes, generates the
// step tick and integrates elevation/azimuth angles in two axis instances.
module motor_position_tracker
  import tracker_pkg::*;
#(
  parameter int ANGLE_W    = 16,
  parameter int TICK_DIV   = 50000,
  parameter int THETA_MIN  = 0,
  parameter int THETA_MAX  = 90,
  parameter int THETA_INIT = 45,
  parameter int PHI_MIN    = 0,
  parameter int PHI_MAX    = 359,
  parameter int PHI_INIT   = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               home,
  input  logic [1:0]         s_in_theta_pos,
  input  logic [1:0]         s_in_theta_neg,
  input  logic [1:0]         s_in_phi_pos,
  input  logic [1:0]         s_in_phi_neg,
  output logic [ANGLE_W-1:0] theta_actual,
  output logic [ANGLE_W-1:0] phi_actual,
  output logic               theta_moving,
  output logic               phi_moving,
  output logic               theta_at_limit,
  output logic               phi_at_limit,
  output logic               fault
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [1:0]         th_pos_q, th_pos_d, th_neg_q, th_neg_d;
  logic [1:0]         ph_pos_q, ph_pos_d, ph_neg_q, ph_neg_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               fault_q, fault_d;
  logic               tick_s, th_fault_s, ph_fault_s;

  assign tick_s = (presc_q == PRESC_LAST);

  always_comb begin
    th_pos_d = s_in_theta_pos;
    th_neg_d = s_in_theta_neg;
    ph_pos_d = s_in_phi_pos;
    ph_neg_d = s_in_phi_neg;
    // home restarts the tick grid so a fresh move always gets a full first tick.
    if (home)        presc_d = '0;
    else if (tick_s) presc_d = '0;
    else             presc_d = presc_q + PRESC_ONE;
    if (home) fault_d = 1'b0;
    else      fault_d = th_fault_s || ph_fault_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_pos_q <= SPD_STOP;
      th_neg_q <= SPD_STOP;
      ph_pos_q <= SPD_STOP;
      ph_neg_q <= SPD_STOP;
      presc_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      th_pos_q <= th_pos_d;
      th_neg_q <= th_neg_d;
      ph_pos_q <= ph_pos_d;
      ph_neg_q <= ph_neg_d;
      presc_q  <= presc_d;
      fault_q  <= fault_d;
    end
  end

  axis_integrator #(
    .ANGLE_W(ANGLE_W), .MIN(THETA_MIN), .MAX(THETA_MAX), .INIT(THETA_INIT)
  ) u_theta (
    .clk(clk), .rst_n(rst_n), .home(home), .tick(tick_s),
    .code_pos(th_pos_q), .code_neg(th_neg_q),
    .angle(theta_actual), .moving(theta_moving),
    .at_limit(theta_at_limit), .in_fault(th_fault_s)
  );

  axis_integrator #(
    .ANGLE_W(ANGLE_W), .MIN(PHI_MIN), .MAX(PHI_MAX), .INIT(PHI_INIT)
  ) u_phi (
    .clk(clk), .rst_n(rst_n), .home(home), .tick(tick_s),
    .code_pos(ph_pos_q), .code_neg(ph_neg_q),
    .angle(phi_actual), .moving(phi_moving),
    .at_limit(phi_at_limit), .in_fault(ph_fault_s)
  );

  assign fault = fault_q;

endmodule
